// File: rtl/wishbone_local_memory_bridge_pkg.sv
// Shared definitions for the Wishbone to local-memory bridge.
package wishbone_local_memory_bridge_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 32;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRequest = 2'd1,
        StRespond = 2'd2,
        StError   = 2'd3
    } bridgeState_t;

endpackage

// File: rtl/wishbone_local_memory_bridge.sv
// Wishbone classic slave that turns one decoded bus cycle into a held request on the
// secondary port of the local memory interface, answering with ack, or with err on a
// malformed access or a timeout.
module wishbone_local_memory_bridge
    import wishbone_local_memory_bridge_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 24,
    parameter logic [WB_ADDR_WIDTH-ADDRESS_SIZE-1:0] BASE_ADDRESS = '0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [ADDRESS_SIZE-1:0]  memAddress,
    output logic [WB_SEL_WIDTH-1:0]  memByteSelect,
    output logic                     memEnable,
    output logic                     memWriteEnable,
    output logic [WB_DATA_WIDTH-1:0] memDataWrite,
    input  logic [WB_DATA_WIDTH-1:0] memDataRead,
    input  logic                     memBusy
);

    localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    bridgeState_t           state;
    logic [COUNT_WIDTH-1:0] timeoutCount;
    logic                   abortHold;
    logic                   hit;
    logic                   invalid;
    logic                   blocked;

    // Address decode and access validity for the cycle currently on the bus.
    always_comb begin
        hit     = wb_cyc_i & wb_stb_i
                & (wb_adr_i[WB_ADDR_WIDTH-1:ADDRESS_SIZE] == BASE_ADDRESS);
        invalid = (wb_adr_i[1:0] != 2'b00) | (wb_sel_i == '0);
        // The master still holds stb while it sees our ack/err, and an abort must leave
        // memEnable low for two cycles; ignore the bus for that one cycle.
        blocked = wb_ack_o | wb_err_o | abortHold;
    end

    // Bridge FSM with registered Wishbone responses and memory request signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            timeoutCount   <= '0;
            abortHold      <= 1'b0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            wb_dat_o       <= '0;
            memAddress     <= '0;
            memByteSelect  <= '0;
            memEnable      <= 1'b0;
            memWriteEnable <= 1'b0;
            memDataWrite   <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                StIdle: begin
                    abortHold <= 1'b0;
                    if (hit && !blocked) begin
                        if (invalid) begin
                            state <= StError;
                        end else begin
                            memAddress     <= wb_adr_i[ADDRESS_SIZE-1:0];
                            memByteSelect  <= wb_sel_i;
                            memWriteEnable <= wb_we_i;
                            memDataWrite   <= wb_dat_i;
                            memEnable      <= 1'b1;
                            timeoutCount   <= '0;
                            state          <= StRequest;
                        end
                    end
                end
                StRequest: begin
                    timeoutCount <= timeoutCount + 1'b1;
                    // Abort outranks both completion and timeout.
                    if (!wb_cyc_i) begin
                        memEnable <= 1'b0;
                        abortHold <= 1'b1;
                        state     <= StIdle;
                    end else if (!memBusy) begin
                        memEnable <= 1'b0;
                        if (!memWriteEnable) begin
                            wb_dat_o <= memDataRead;
                        end
                        state <= StRespond;
                    end else if (timeoutCount == COUNT_LAST) begin
                        memEnable <= 1'b0;
                        state     <= StError;
                    end
                end
                StRespond: begin
                    wb_ack_o <= wb_cyc_i;
                    state    <= StIdle;
                end
                StError: begin
                    wb_err_o <= wb_cyc_i;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_local_memory_bridge.sv
// Self-checking bench for wishbone_local_memory_bridge: directed cases plus random
// transfers checked against a transaction-level expectation model.
module tb_wishbone_local_memory_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbCyc, wbStb, wbWe;
    logic [3:0]  wbSel;
    logic [31:0] wbAdr, wbDatIn;
    logic        wbAck, wbErr;
    logic [31:0] wbDatOut;
    logic [23:0] memAddress;
    logic [3:0]  memByteSelect;
    logic        memEnable, memWriteEnable;
    logic [31:0] memDataWrite, memDataRead;
    logic        memBusy;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    logic [31:0] modelDat = 32'h0;

    wishbone_local_memory_bridge #(
        .ADDRESS_SIZE  (24),
        .BASE_ADDRESS  (8'h00),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_cyc_i      (wbCyc),
        .wb_stb_i      (wbStb),
        .wb_we_i       (wbWe),
        .wb_sel_i      (wbSel),
        .wb_adr_i      (wbAdr),
        .wb_dat_i      (wbDatIn),
        .wb_ack_o      (wbAck),
        .wb_err_o      (wbErr),
        .wb_dat_o      (wbDatOut),
        .memAddress    (memAddress),
        .memByteSelect (memByteSelect),
        .memEnable     (memEnable),
        .memWriteEnable(memWriteEnable),
        .memDataWrite  (memDataWrite),
        .memDataRead   (memDataRead),
        .memBusy       (memBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; memBusy is 1 for the first 'busy' request-cycle samples.
    // Cycle n=1 is the edge at which stb is sampled.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int busy, input logic [31:0] rd);
        bit hit, inv, memOk, protoOk;
        int expKind, expAt, expEn, kind, at, enCnt;
        logic [31:0] expDat, seenDat;
        hit = (adr[31:24] == 8'h00);
        inv = (adr[1:0] != 2'b00) || (sel == 4'h0);
        if (!hit) begin
            expKind = 0; expAt = 0;     expEn = 0;
        end else if (inv) begin
            expKind = 2; expAt = 2;     expEn = 0;
        end else if (busy <= T - 1) begin
            expKind = 1; expAt = busy + 3; expEn = busy + 1;
        end else begin
            expKind = 2; expAt = T + 2; expEn = T;
        end
        expDat = (expKind == 1 && !we) ? rd : modelDat;

        @(negedge clk);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = we; wbSel = sel; wbAdr = adr; wbDatIn = dat;
        memBusy = (busy >= 1); memDataRead = rd;
        kind = 0; at = 0; enCnt = 0; memOk = 1'b1; protoOk = 1'b1; seenDat = wbDatOut;
        for (int n = 1; n <= T + 6 && kind == 0; n++) begin
            @(posedge clk); #1;
            if (memEnable) begin
                enCnt++;
                if (memAddress !== adr[23:0] || memByteSelect !== sel ||
                    memWriteEnable !== we || memDataWrite !== dat) memOk = 1'b0;
            end
            if (wbAck && wbErr) protoOk = 1'b0;
            if (wbAck) begin kind = 1; at = n; seenDat = wbDatOut; end
            else if (wbErr) begin kind = 2; at = n; seenDat = wbDatOut; end
            memBusy = (n <= busy);
        end
        if (kind == 0) seenDat = wbDatOut;
        check("response kind", 64'(kind), 64'(expKind));
        check("response cycle", 64'(at), 64'(expAt));
        check("memEnable cycles", 64'(enCnt), 64'(expEn));
        check("mem request stable", 64'(memOk), 64'd1);
        check("wb_dat_o", 64'(seenDat), 64'(expDat));
        // Master keeps cyc through the edge at which it samples the response.
        @(posedge clk); #1;
        if (wbAck && wbErr) protoOk = 1'b0;
        check("response single cycle", 64'(wbAck | wbErr), 64'd0);
        check("ack/err exclusive", 64'(protoOk), 64'd1);
        wbCyc = 1'b0; wbStb = 1'b0; memBusy = 1'b0;
        @(posedge clk); #1;
        check("memEnable idle", 64'(memEnable), 64'd0);
        modelDat = expDat;
    endtask

    initial begin
        bit quiet;
        logic [31:0] adr, rd;
        logic [3:0] sel;
        int busy, r;

        rst = 1'b1; wbCyc = 0; wbStb = 0; wbWe = 0; wbSel = 0; wbAdr = 0; wbDatIn = 0;
        memDataRead = 0; memBusy = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset memEnable", 64'(memEnable), 64'd0);
        check("reset ack/err", 64'({wbAck, wbErr}), 64'd0);
        check("reset wb_dat_o", 64'(wbDatOut), 64'd0);
        check("reset mem outputs",
              64'({memAddress, memByteSelect, memWriteEnable}), 64'd0);
        check("reset memDataWrite", 64'(memDataWrite), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases.
        xfer(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 3, 32'h0);
        xfer(1'b0, 32'h0000_0010, 4'h3, 32'h0, 0, 32'hFFFF_BEEF);
        xfer(1'b0, 32'h0000_0012, 4'hF, 32'h0, 0, 32'h1234_5678);
        xfer(1'b1, 32'h0000_0020, 4'h0, 32'h5555_AAAA, 0, 32'h0);
        xfer(1'b0, 32'h0100_0000, 4'hF, 32'h0, 0, 32'h0BAD_F00D);
        xfer(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1000, 32'h7777_7777);
        xfer(1'b0, 32'h0000_0044, 4'hF, 32'h0, T - 1, 32'hCAFE_0001);

        // Abort in the second request cycle.
        @(negedge clk);
        wbCyc = 1; wbStb = 1; wbWe = 0; wbSel = 4'hF; wbAdr = 32'h80; memBusy = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wbCyc = 0; wbStb = 0;
        @(posedge clk); #1;
        check("abort memEnable", 64'(memEnable), 64'd0);
        quiet = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (wbAck || wbErr || memEnable) quiet = 1'b0;
        end
        memBusy = 0;
        check("abort no response", 64'(quiet), 64'd1);
        xfer(1'b0, 32'h0000_0084, 4'hF, 32'h0, 2, 32'h0101_0202);

        // Reset during a request.
        @(negedge clk);
        wbCyc = 1; wbStb = 1; wbWe = 1; wbSel = 4'hC; wbAdr = 32'h90; wbDatIn = 32'h1; memBusy = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("async reset memEnable", 64'(memEnable), 64'd0);
        @(negedge clk);
        rst = 1'b0; wbCyc = 0; wbStb = 0; memBusy = 0;
        quiet = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (wbAck || wbErr || memEnable) quiet = 1'b0;
        end
        check("reset no response", 64'(quiet), 64'd1);
        modelDat = 32'h0;
        xfer(1'b1, 32'h0000_0094, 4'hF, 32'h3333_4444, 1, 32'h0);

        // Random transfers.
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            adr = {8'h00, 22'($urandom), 2'b00};
            if (r == 0) adr[31:24] = 8'($urandom_range(1, 255));
            if (r == 1) adr[1:0] = 2'($urandom_range(1, 3));
            sel = (r == 2) ? 4'h0 : 4'($urandom_range(1, 15));
            busy = (r == 3) ? T + $urandom_range(0, 2) : $urandom_range(0, 5);
            rd = $urandom;
            for (int b = 0; b < 4; b++) if (!sel[b]) rd[b*8 +: 8] = 8'hFF;
            xfer(1'($urandom_range(0, 1)), adr, sel, $urandom, busy, rd);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
